// File: rtl/pm_loader.sv
// Nibble-serial program memory loader: receives length, data and checksum bytes,
// writes each data byte into program memory and holds the CPU until a good load completes.
module pm_loader #(
    parameter logic HOLD_AT_RESET = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] nib_in,
    input  logic       nib_valid,
    output logic       nib_ready,
    output logic [7:0] pm_waddr,
    output logic [7:0] pm_wdata,
    output logic       pm_we,
    output logic       cpu_hold,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [3:0] {
        IDLE, LEN_HI, LEN_LO, DAT_HI, DAT_LO, WRITE, CHK_HI, CHK_LO, DONE, ERROR
    } state_t;

    state_t     state_reg, state_next;
    logic [3:0] hi_reg;
    logic [7:0] len_m1_reg;
    logic [7:0] addr_reg;
    logic [7:0] csum_reg;
    logic [7:0] waddr_reg;
    logic [7:0] wdata_reg;
    logic [7:0] rx_byte;
    logic       accept;

    assign rx_byte  = {hi_reg, nib_in};
    assign pm_waddr = waddr_reg;
    assign pm_wdata = wdata_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        nib_ready  = 1'b0;
        busy       = 1'b1;
        case (state_reg)
            LEN_HI, LEN_LO, DAT_HI, DAT_LO, CHK_HI, CHK_LO: nib_ready = 1'b1;
            IDLE, DONE, ERROR:                              busy      = 1'b0;
            default: ;
        endcase
        accept = nib_ready && nib_valid;

        if (!busy) begin
            if (start) state_next = LEN_HI;
        end else if (abort) begin
            state_next = ERROR;
        end else begin
            case (state_reg)
                LEN_HI: if (accept) state_next = LEN_LO;
                LEN_LO: if (accept) state_next = DAT_HI;
                DAT_HI: if (accept) state_next = DAT_LO;
                DAT_LO: if (accept) state_next = WRITE;
                // len_m1 holds N-1, so a length byte of 0 runs the full 256 writes
                WRITE:  state_next = (addr_reg == len_m1_reg) ? CHK_HI : DAT_HI;
                CHK_HI: if (accept) state_next = CHK_LO;
                CHK_LO: if (accept) state_next = (rx_byte == csum_reg) ? DONE : ERROR;
                default: state_next = state_reg;
            endcase
        end

        pm_we    = (state_reg == WRITE) && !abort;
        done     = (state_reg == DONE);
        err      = (state_reg == ERROR);
        cpu_hold = (state_reg == IDLE) ? HOLD_AT_RESET : (state_reg != DONE);
    end

    // Datapath; an abort freezes everything so a discarded nibble or write leaves no trace
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_reg     <= 4'h0;
            len_m1_reg <= 8'h00;
            addr_reg   <= 8'h00;
            csum_reg   <= 8'h00;
            waddr_reg  <= 8'h00;
            wdata_reg  <= 8'h00;
        end else if (!busy) begin
            if (start) begin
                addr_reg <= 8'h00;
                csum_reg <= 8'h00;
            end
        end else if (!abort) begin
            case (state_reg)
                LEN_HI, DAT_HI, CHK_HI: begin
                    if (accept) hi_reg <= nib_in;
                end
                LEN_LO: begin
                    if (accept) begin
                        len_m1_reg <= rx_byte - 8'd1;
                        csum_reg   <= csum_reg + rx_byte;
                    end
                end
                DAT_LO: begin
                    if (accept) begin
                        waddr_reg <= addr_reg;
                        wdata_reg <= rx_byte;
                    end
                end
                WRITE: begin
                    csum_reg <= csum_reg + wdata_reg;
                    addr_reg <= addr_reg + 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pm_loader.sv
// Directed bench for pm_loader: table of complete loads plus hand-written
// sequences for abort, mid-load reset and first start after reset.
module tb_pm_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] nib_in = 4'h0;
    logic       nib_valid = 1'b0;
    logic       nib_ready;
    logic [7:0] pm_waddr;
    logic [7:0] pm_wdata;
    logic       pm_we;
    logic       cpu_hold;
    logic       busy;
    logic       done;
    logic       err;

    int checks = 0;
    int errors = 0;
    logic [15:0] wq[$];

    typedef struct {
        logic [7:0] len;
        int         pat;
        logic [7:0] csum;
        bit         gaps;
        bit         exp_done;
        bit         exp_err;
        int         nwr;
    } vec_t;

    vec_t vecs[5];

    pm_loader #(.HOLD_AT_RESET(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .nib_in(nib_in), .nib_valid(nib_valid), .nib_ready(nib_ready),
        .pm_waddr(pm_waddr), .pm_wdata(pm_wdata), .pm_we(pm_we),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pm_we === 1'b1) wq.push_back({pm_waddr, pm_wdata});
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] dbyte(input int pat, input int k);
        if (pat == 0) begin
            case (k)
                0:       return 8'hAB;
                1:       return 8'h12;
                default: return 8'hF0;
            endcase
        end
        return 8'(k * 7 + 3);
    endfunction

    task automatic send_nib(input logic [3:0] n, input bit gaps);
        bit acc = 1'b0;
        int guard = 0;
        if (gaps) begin
            int g = int'($urandom_range(0, 3));
            repeat (g) begin
                nib_valid = 1'b0;
                start = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
        nib_in = n;
        nib_valid = 1'b1;
        while (!acc && guard < 50) begin
            @(negedge clk);
            acc = nib_ready;
            @(posedge clk); #1;
            guard++;
        end
        nib_valid = 1'b0;
        chk("nib_handshake", 32'(acc), 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        send_nib(b[7:4], gaps);
        send_nib(b[3:0], gaps);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (busy && guard < 100);
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic run_vec(input int i, input bit started);
        int n;
        vec_t v;
        v = vecs[i];
        n = (v.len == 8'h00) ? 256 : int'(v.len);
        wq.delete();
        if (!started) pulse_start();
        send_byte(v.len, v.gaps);
        for (int k = 0; k < n; k++) send_byte(dbyte(v.pat, k), v.gaps);
        send_byte(v.csum, v.gaps);
        wait_idle();
        chk($sformatf("v%0d_nwrites", i), 32'(wq.size()), 32'(v.nwr));
        for (int k = 0; k < wq.size() && k < n; k++) begin
            chk($sformatf("v%0d_waddr%0d", i, k), 32'(wq[k][15:8]), 32'(k));
            chk($sformatf("v%0d_wdata%0d", i, k), 32'(wq[k][7:0]), 32'(dbyte(v.pat, k)));
        end
        chk($sformatf("v%0d_done", i), 32'(done), 32'(v.exp_done));
        chk($sformatf("v%0d_err", i), 32'(err), 32'(v.exp_err));
        chk($sformatf("v%0d_cpu_hold", i), 32'(cpu_hold), 32'(!v.exp_done));
        $display("vec %0d: len=%h writes=%0d done=%b err=%b cpu_hold=%b",
                 i, v.len, wq.size(), done, err, cpu_hold);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_nib_ready"}, 32'(nib_ready), 32'd0);
        chk({tag, "_pm_we"}, 32'(pm_we), 32'd0);
        chk({tag, "_pm_waddr"}, 32'(pm_waddr), 32'h00);
        chk({tag, "_pm_wdata"}, 32'(pm_wdata), 32'h00);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
    endtask

    initial begin
        // Good sum for 03,AB,12,F0 is 0xB0; 256-byte ramp 7k+3 sums to 0x80; 01+03 = 0x04
        vecs[0] = '{len: 8'h03, pat: 0, csum: 8'hB0, gaps: 1'b0, exp_done: 1'b1, exp_err: 1'b0, nwr: 3};
        vecs[1] = '{len: 8'h03, pat: 0, csum: 8'h00, gaps: 1'b0, exp_done: 1'b0, exp_err: 1'b1, nwr: 3};
        vecs[2] = '{len: 8'h00, pat: 1, csum: 8'h80, gaps: 1'b0, exp_done: 1'b1, exp_err: 1'b0, nwr: 256};
        vecs[3] = '{len: 8'h03, pat: 0, csum: 8'hB0, gaps: 1'b1, exp_done: 1'b1, exp_err: 1'b0, nwr: 3};
        vecs[4] = '{len: 8'h01, pat: 1, csum: 8'h04, gaps: 1'b0, exp_done: 1'b1, exp_err: 1'b0, nwr: 1};

        #1;
        chk_reset_outputs("por");

        // Start presented together with reset release is taken on the first edge
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("first_start_busy", 32'(busy), 32'd1);
        chk("first_start_ready", 32'(nib_ready), 32'd1);
        run_vec(0, 1'b1);

        for (int i = 0; i < 5; i++) run_vec(i, 1'b0);

        // Abort in the same cycle the DAT_LO nibble is accepted
        wq.delete();
        pulse_start();
        send_byte(8'h03, 1'b0);
        send_nib(4'hA, 1'b0);
        nib_in = 4'hB;
        nib_valid = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        chk("abort_in_dat_lo", 32'(nib_ready), 32'd1);
        @(posedge clk); #1;
        abort = 1'b0;
        nib_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_writes", 32'(wq.size()), 32'd0);
        chk("abort_err", 32'(err), 32'd1);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        $display("abort: writes=%0d err=%b cpu_hold=%b", wq.size(), err, cpu_hold);
        run_vec(0, 1'b0);

        // Reset pulsed mid-load while waiting in DAT_HI with non-zero write registers
        pulse_start();
        send_byte(8'h03, 1'b0);
        send_byte(8'hAB, 1'b0);
        send_byte(8'h12, 1'b0);
        @(posedge clk); #1;
        chk("pre_reset_waddr", 32'(pm_waddr), 32'h01);
        chk("pre_reset_in_dat_hi", 32'(nib_ready), 32'd1);
        wq.delete();
        nib_in = 4'hF;
        nib_valid = 1'b1;
        reset = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        repeat (3) @(negedge clk);
        chk("midrst_writes", 32'(wq.size()), 32'd0);
        nib_valid = 1'b0;
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("restart_busy", 32'(busy), 32'd1);
        $display("mid-load reset: writes after reset=%0d", wq.size());
        run_vec(0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
